unified_mem_arbiter: RTL
========================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the instruction-fetch port and the data load/store port.
//  Sits between the core (fetch address, dmem access) and the memory. Used when imem/dmem are merged into one array.
//  Arbitrates, latches the winner's request, runs a req/ack handshake, returns data and drives per-port stalls.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width
//  MAX_WAIT  15  ISSUE cycles without mem_ack before abort (>=1)
// PORTS
//  clock        in   1       system clock, all state on posedge
//  reset        in   1       synchronous, active-low: reset==0 at posedge initialises all state
//  if_req       in   1       fetch request; held with if_addr until if_valid
//  if_addr      in   ADDR_W  fetch address (word access)
//  if_rdata     out  DATA_W  fetched instruction, valid with if_valid
//  if_valid     out  1       one-cycle fetch completion pulse
//  if_stall     out  1       if_req & ~if_valid (combinational)
//  d_req        in   1       data request; held with d_* until d_valid
//  d_rw         in   1       1=write, 0=read
//  d_addr       in   ADDR_W  data address
//  d_wdata      in   DATA_W  store data
//  d_size       in   2       00 byte, 01 half, 10 word (passed through)
//  d_rdata      out  DATA_W  load data; 0 on write completion
//  d_valid      out  1       one-cycle data completion pulse
//  d_stall      out  1       d_req & ~d_valid (combinational)
//  mem_req      out  1       memory request, high for whole ISSUE state
//  mem_rw       out  1       latched rw (0 for fetch)
//  mem_addr     out  ADDR_W  latched address
//  mem_wdata    out  DATA_W  latched store data (0 for fetch)
//  mem_size     out  2       latched size (10 for fetch)
//  mem_ack      in   1       memory completion; mem_rdata valid same cycle
//  mem_rdata    in   DATA_W  memory read data
//  timeout_err  out  1       sticky: set on any abort, cleared only by reset
// BEHAVIOUR
//  Reset (reset==0): state=IDLE, last_grant=IF, wait_cnt=0; every registered output 0 (mem_*, *_valid, *_rdata, timeout_err).
//  States: IDLE -> ISSUE -> RESP -> IDLE. All outputs except *_stall are registered.
//  IDLE: if_req/d_req sampled only here. None: stay. One: grant it. Both: grant port != last_grant (reset: D wins first).
//   On grant: latch owner, mem_rw/addr/wdata/size, mem_req<=1, wait_cnt<=0, last_grant<=owner, ->ISSUE.
//  ISSUE: mem_* held stable. mem_ack=1: capture mem_rdata (0 if write), mem_req<=0, ->RESP.
//   No ack: wait_cnt++; when wait_cnt==MAX_WAIT-1 with no ack: mem_req<=0, rdata<=0, timeout_err<=1, ->RESP.
//  RESP: owner's *_valid=1 and *_rdata driven for exactly this cycle; requests NOT sampled; ->IDLE.
//   Requester drops req on its valid cycle unless issuing a new request (new one seen next IDLE cycle).
//  Latency: req seen at edge N -> mem_req cycle N+1; ack in N+1 -> valid in cycle N+2. Min 3 cycles/transaction.
//  Fairness: with both ports continuously requesting, grants alternate D,I,D,I...; no starvation.
//  Ack outside ISSUE ignored. wait_cnt width clog2(MAX_WAIT)+1, never wraps.
//  Req dropped mid-transaction: transaction completes on latched values; valid still pulses.
//  Reset low mid-ISSUE/RESP: transaction discarded, no valid pulse, mem_req 0 after that edge.
//  *_rdata holds last value outside RESP; only meaningful while matching *_valid=1.
// TESTING
//  Reset: hold reset=0 3 cycles with if_req=1 -> all outputs 0, mem_req stays 0; release -> mem_req 1 next cycle.
//  Fetch: if_addr=0x01000000, ack 1st ISSUE cycle, mem_rdata=0x00500093 -> if_valid 1 cycle, if_rdata=0x00500093, 3-cycle period.
//  Contention: if_req=d_req=1 continuous, immediate acks -> grant order D,I,D,I; d_stall=1 during I ownership.
//  Store: d_rw=1,d_addr=0x01000100,d_wdata=0xDEADBEEF,d_size=10, ack after 4 cycles -> mem_* stable 5 cycles, d_valid, d_rdata=0.
//  Timeout: MAX_WAIT=15, never ack -> mem_req drops after 15 ISSUE cycles, d_valid 1 with d_rdata=0, timeout_err stays 1.
//  Reset mid-ISSUE: reset=0 in 2nd ISSUE cycle -> no valid pulse, mem_req 0, timeout_err 0, state IDLE.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   port and the data load/store port. A request is sampled only while idle,
//   the winner's fields are latched and presented to memory until mem_ack (or
//   an abort after MAX_WAIT issue cycles), then a one-cycle completion pulse
//   returns data to the owning port. When both ports request, the port that
//   did not win last time is granted.
//
// Ports
//   clock, reset            : clock; synchronous active-low reset
//   if_req/if_addr          : fetch request and word address
//   if_rdata/if_valid       : fetched instruction and completion pulse
//   if_stall                : if_req & ~if_valid
//   d_req/d_rw/d_addr/
//   d_wdata/d_size          : data request (rw 1=write), size passed through
//   d_rdata/d_valid         : load data (0 on write/abort) and completion pulse
//   d_stall                 : d_req & ~d_valid
//   mem_req/mem_rw/mem_addr/
//   mem_wdata/mem_size      : latched request presented to memory
//   mem_ack/mem_rdata       : memory completion and read data
//   timeout_err             : sticky abort flag, cleared only by reset
module unified_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(MAX_WAIT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_owner_d;   // 1: data port owns the current transaction
  logic              r_last_d;    // 1: data port won the previous grant
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              w_grant, w_grant_d, w_done, w_abort;
  logic [DATA_W-1:0] w_resp_data;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_d   = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (if_req || d_req) begin
          w_grant     = 1'b1;
          // Data wins when alone, or on contention when fetch won last time.
          w_grant_d   = d_req && (!if_req || !r_last_d);
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Writes and aborts return zero data.
  assign w_resp_data = (w_done && !mem_rw) ? mem_rdata : '0;

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_owner_d   <= 1'b0;
      r_last_d    <= 1'b0;
      r_wait_cnt  <= '0;
      mem_req     <= 1'b0;
      mem_rw      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_size    <= '0;
      if_rdata    <= '0;
      if_valid    <= 1'b0;
      d_rdata     <= '0;
      d_valid     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;

      if (w_grant) begin
        r_owner_d  <= w_grant_d;
        r_last_d   <= w_grant_d;
        r_wait_cnt <= '0;
        mem_req    <= 1'b1;
        if (w_grant_d) begin
          mem_rw    <= d_rw;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          mem_size  <= d_size;
        end else begin
          mem_rw    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_size  <= 2'b10;
        end
      end

      if (r_state == S_ISSUE && !w_done && !w_abort) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end

      if (w_done || w_abort) begin
        mem_req <= 1'b0;
        if (w_abort) begin
          timeout_err <= 1'b1;
        end
        if (r_owner_d) begin
          d_valid <= 1'b1;
          d_rdata <= w_resp_data;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= w_resp_data;
        end
      end
    end
  end

endmodule
